// File: rtl/svc_rv_imem_bram_if.sv
// Fetch and loader bus between the IF stage / bootloader and the instruction BRAM.
// Carries imem_err only when SVC_RV_IMEM_FETCH_ERR_EN is defined.
interface svc_rv_imem_bram_if #(
  parameter int AW = 10
);
  logic        imem_ren;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
`ifdef SVC_RV_IMEM_FETCH_ERR_EN
  logic        imem_err;
`endif
  logic        load_start;
  logic [31:0] load_base;
  logic [AW:0] load_len;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        loading;
  logic        load_done;

`ifdef SVC_RV_IMEM_FETCH_ERR_EN
  modport master (
    output imem_ren, imem_raddr, load_start, load_base, load_len, load_valid, load_data,
    input  imem_rdata, imem_err, load_ready, loading, load_done
  );
  modport slave (
    input  imem_ren, imem_raddr, load_start, load_base, load_len, load_valid, load_data,
    output imem_rdata, imem_err, load_ready, loading, load_done
  );
`else
  modport master (
    output imem_ren, imem_raddr, load_start, load_base, load_len, load_valid, load_data,
    input  imem_rdata, load_ready, loading, load_done
  );
  modport slave (
    input  imem_ren, imem_raddr, load_start, load_base, load_len, load_valid, load_data,
    output imem_rdata, load_ready, loading, load_done
  );
`endif
endinterface

// File: rtl/svc_rv_imem_bram.sv
// Single-clock instruction BRAM with 1-cycle registered fetch and a byte-stream program loader.
// Optional feature macro: SVC_RV_IMEM_FETCH_ERR_EN adds the registered imem_err fetch flag.
module svc_rv_imem_bram #(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input logic              clk,
  input logic              rst_n,
  svc_rv_imem_bram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] I_NOP = 32'h0000_0013;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t        state, state_next;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [1:0]    bcnt;
  logic [AW:0]   left;
  logic [23:0]   asm_word;
  logic          accept;
  logic          wr_en;
  logic [AW-1:0] idx;
  logic          oob;
  logic          unused_base;

  assign bus.loading    = (state == LOAD);
  assign bus.load_ready = (state == LOAD);
  assign accept         = bus.loading && bus.load_valid;
  assign wr_en          = accept && (bcnt == 2'd3);
  assign idx            = bus.imem_raddr[AW+1:2];
  assign oob            = |bus.imem_raddr[31:AW+2];
  assign unused_base    = ^{bus.load_base[31:AW+2], bus.load_base[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.load_start && (bus.load_len != '0)) state_next = LOAD;
      LOAD: if (wr_en && (left == {{AW{1'b0}}, 1'b1})) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word assembly, pointer and remaining-count bookkeeping; a reset drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      bcnt          <= '0;
      left          <= '0;
      asm_word      <= '0;
      bus.load_done <= 1'b0;
    end else begin
      bus.load_done <= 1'b0;
      if (state == IDLE) begin
        if (bus.load_start) begin
          ptr  <= bus.load_base[AW+1:2];
          bcnt <= '0;
          left <= bus.load_len;
          if (bus.load_len == '0) bus.load_done <= 1'b1;
        end
      end else if (accept) begin
        if (bcnt == 2'd3) begin
          bcnt <= '0;
          ptr  <= ptr + 1'b1;
          left <= left - 1'b1;
          if (left == {{AW{1'b0}}, 1'b1}) bus.load_done <= 1'b1;
        end else begin
          case (bcnt)
            2'd0:    asm_word[7:0]   <= bus.load_data;
            2'd1:    asm_word[15:8]  <= bus.load_data;
            default: asm_word[23:16] <= bus.load_data;
          endcase
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= {bus.load_data, asm_word};
  end

  // Fetch data holds while ren is low so IF can stall on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imem_rdata <= I_NOP;
`ifdef SVC_RV_IMEM_FETCH_ERR_EN
      bus.imem_err   <= 1'b0;
`endif
    end else if (bus.imem_ren) begin
      bus.imem_rdata <= (bus.loading || oob) ? I_NOP : mem[idx];
`ifdef SVC_RV_IMEM_FETCH_ERR_EN
      bus.imem_err   <= !bus.loading && (oob || (bus.imem_raddr[1:0] != 2'b00));
`endif
    end
  end
endmodule

// File: tb/tb_svc_rv_imem_bram.sv
// Self-checking bench for svc_rv_imem_bram: directed loads/fetches plus randomized loads against a word-array model.
// Honours SVC_RV_IMEM_FETCH_ERR_EN when checking imem_err.
module tb_svc_rv_imem_bram;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];
  logic [31:0] load_q [$];

  svc_rv_imem_bram_if #(.AW(AW)) bus ();

  svc_rv_imem_bram #(.DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_err(input string tag, input logic exp);
`ifdef SVC_RV_IMEM_FETCH_ERR_EN
    check_output(tag, {31'd0, bus.imem_err}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("[TB] %s unused", tag);
`endif
  endtask

  // Loads load_q starting at word index base_idx; optionally probes a fetch during the load.
  task automatic apply_stimulus(input int base_idx, input bit probe);
    int n = load_q.size();
    int gaps;
    bus.load_base  = 32'(base_idx * 4) | 32'($urandom_range(0, 3));
    bus.load_len   = (AW+1)'(n);
    bus.load_start = 1'b1;
    tick();
    check_output("load_enter_loading", {31'd0, bus.loading}, 32'd1);
    check_output("load_enter_ready", {31'd0, bus.load_ready}, 32'd1);
    bus.load_start = 1'b0;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        gaps = 0;
        while (gaps < 2 && $urandom_range(0, 3) == 0) begin
          bus.load_valid = 1'b0;
          tick();
          check_output("gap_loading", {31'd0, bus.loading}, 32'd1);
          gaps++;
        end
        bus.load_valid = 1'b1;
        bus.load_data  = load_q[w][8*b +: 8];
        if (w == 0 && b == 1) begin
          bus.load_start = 1'b1;
          bus.load_base  = 32'h0000_0020;
        end
        if (probe && w == 0 && b == 0) begin
          bus.imem_ren   = 1'b1;
          bus.imem_raddr = 32'h0;
        end
        tick();
        bus.load_start = 1'b0;
        bus.imem_ren   = 1'b0;
        if (probe && w == 0 && b == 0) begin
          check_output("fetch_during_load", bus.imem_rdata, NOP);
          check_err("err_during_load", 1'b0);
        end
        if (!(w == n - 1 && b == 3))
          check_output("no_early_done", {31'd0, bus.load_done}, 32'd0);
      end
    end
    bus.load_valid = 1'b0;
    check_output("load_done_pulse", {31'd0, bus.load_done}, 32'd1);
    check_output("loading_dropped", {31'd0, bus.loading}, 32'd0);
    for (int w = 0; w < n; w++) begin
      model_mem[(base_idx + w) % DEPTH] = load_q[w];
      known[(base_idx + w) % DEPTH] = 1'b1;
    end
    tick();
    check_output("load_done_single", {31'd0, bus.load_done}, 32'd0);
  endtask

  task automatic fetch_check(input string tag, input logic [31:0] addr);
    logic [31:0] exp;
    bit oob = (addr >> (AW + 2)) != 0;
    int i = int'((addr >> 2) % DEPTH);
    bus.imem_ren   = 1'b1;
    bus.imem_raddr = addr;
    tick();
    bus.imem_ren = 1'b0;
    exp = oob ? NOP : model_mem[i];
    if (oob || known[i]) check_output(tag, bus.imem_rdata, exp);
    check_err({tag, "_err"}, oob || (addr[1:0] != 2'b00));
  endtask

  initial begin
    logic [31:0] held;
    int n, base, i;
    bus.imem_ren = 1'b0; bus.imem_raddr = '0; bus.load_start = 1'b0; bus.load_base = '0;
    bus.load_len = '0; bus.load_valid = 1'b0; bus.load_data = '0;
    for (int k = 0; k < DEPTH; k++) known[k] = 1'b0;

    tick(); tick();
    check_output("reset_rdata", bus.imem_rdata, NOP);
    check_output("reset_ready", {31'd0, bus.load_ready}, 32'd0);
    check_output("reset_loading", {31'd0, bus.loading}, 32'd0);
    check_output("reset_done", {31'd0, bus.load_done}, 32'd0);
    check_err("reset_err", 1'b0);
    rst_n = 1'b1;
    tick();

    load_q = '{32'h00a0_0513, 32'h0010_0593};
    apply_stimulus(0, 1'b1);

    fetch_check("fetch_word1", 32'd4);
    held = 32'h0010_0593;
    for (int k = 0; k < 3; k++) begin
      bus.imem_raddr = 32'd0;
      tick();
      check_output("stall_hold", bus.imem_rdata, held);
    end
    fetch_check("fetch_oob_depth", 32'(DEPTH * 4));
    fetch_check("fetch_misaligned", 32'd2);
    fetch_check("fetch_oob_high", 32'h8000_0000);
    fetch_check("fetch_word0", 32'd0);

    load_q = '{32'hdead_beef};
    apply_stimulus(2, 1'b0);

    // Abort a load of word 2 after two bytes.
    bus.load_base = 32'd8; bus.load_len = (AW+1)'(1); bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.load_valid = 1'b1; bus.load_data = 8'h5a;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_output("abort_loading", {31'd0, bus.loading}, 32'd0);
    check_output("abort_ready", {31'd0, bus.load_ready}, 32'd0);
    check_output("abort_rdata", bus.imem_rdata, NOP);
    tick();
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.load_data = 8'hc3;
      tick();
      check_output("idle_not_ready", {31'd0, bus.load_ready}, 32'd0);
    end
    bus.load_valid = 1'b0;
    fetch_check("abort_kept_word", 32'd8);

    bus.load_base = 32'd0; bus.load_len = '0; bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check_output("len0_loading", {31'd0, bus.loading}, 32'd0);
    check_output("len0_done", {31'd0, bus.load_done}, 32'd1);
    tick();
    check_output("len0_done_single", {31'd0, bus.load_done}, 32'd0);
    fetch_check("len0_no_write", 32'd0);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      base = (r == 0) ? DEPTH - 2 : $urandom_range(0, DEPTH - 1);
      load_q.delete();
      for (int k = 0; k < n; k++) load_q.push_back($urandom);
      apply_stimulus(base, r[0]);
    end

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        fetch_check("rand_oob", 32'((DEPTH + $urandom_range(0, 100)) * 4));
      end else begin
        i = $urandom_range(0, DEPTH - 1);
        for (int t = 0; t < 200 && !known[i]; t++) i = $urandom_range(0, DEPTH - 1);
        if (!known[i]) i = 0;
        fetch_check("rand_fetch", 32'(i * 4) | 32'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
